// File: rtl/self_ex_slink_diag_pkg.sv
// Shared FSM encoding and default timing constants for the SLINK diagnosis sequencer.
// No logic here; latency and backpressure are defined by the users of the package.
package self_ex_slink_diag_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_EVAL   = 2'd3
   } diag_state_t;

   localparam int SETTLE_CYC_DEF = 16;
   localparam int WIN_CYC_DEF    = 64;
   localparam int ERR_THR_DEF    = 8;

endpackage

// File: rtl/self_ex_slink_err_cnt.sv
// Per-channel saturating error-cycle counter; ge_thr is combinational from the count register.
// One cycle from inc to count update; no backpressure, inc is a level sampled when en is high.
module self_ex_slink_err_cnt
   import self_ex_slink_diag_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int ERR_THR = ERR_THR_DEF
) (
   input  logic clk_12_5m,
   input  logic rst_12_5m,
   input  logic clr,
   input  logic en,
   input  logic inc,
   output logic ge_thr
);

   logic [CNT_W-1:0] err_cnt;

   // Stops at the threshold so the verdict can never be lost to a wrap.
   always_ff @(posedge clk_12_5m) begin
      if (rst_12_5m || clr) begin
         err_cnt <= '0;
      end else if (en && inc && (err_cnt < CNT_W'(ERR_THR))) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

   assign ge_thr = (err_cnt >= CNT_W'(ERR_THR));

endmodule

// File: rtl/self_ex_slink_diag_ctrl.sv
// Scheduled SLINK health diagnosis: settle, sample window, evaluate into sticky per-channel faults.
// Verdict visible SETTLE_CYC+WIN_CYC+2 cycles after start; no backpressure, chn_enable change aborts.
module self_ex_slink_diag_ctrl
   import self_ex_slink_diag_pkg::*;
#(
   parameter int CHN_NUM    = 2,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF,
   parameter int WIN_CYC    = WIN_CYC_DEF,
   parameter int ERR_THR    = ERR_THR_DEF,
   parameter int CNT_W      = 8,
   parameter bit AUTO_RUN   = 1'b1
) (
   input  logic               clk_12_5m,
   input  logic               rst_12_5m,
   input  logic               chn_enable,
   input  logic [CHN_NUM-1:0] chn_slink_err,
   input  logic               diag_start,
   input  logic               fault_clr,
   output logic               diag_busy,
   output logic               diag_done,
   output logic               diag_abort,
   output logic [CHN_NUM-1:0] chn_fault,
   output logic               slink_err
);

   diag_state_t        state, state_nxt;
   logic [CNT_W-1:0]   ph_cnt;
   logic               chn_en_q;
   logic               en_chg, run_go, abort_go, eval_ok, smp_en;
   logic [CHN_NUM-1:0] mask, ge_thr, eval_set, fault_nxt;

   assign mask   = chn_enable ? {CHN_NUM{1'b1}} : CHN_NUM'(1);
   assign en_chg = (chn_enable != chn_en_q);
   assign smp_en = (state == ST_SAMPLE);

   always_comb begin
      state_nxt = state;
      run_go    = 1'b0;
      abort_go  = 1'b0;
      eval_ok   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (AUTO_RUN || diag_start) begin
               state_nxt = ST_SETTLE;
               run_go    = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (en_chg) begin
               state_nxt = ST_IDLE;
               abort_go  = 1'b1;
            end else if (ph_cnt == CNT_W'(SETTLE_CYC - 1)) begin
               state_nxt = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            if (en_chg) begin
               state_nxt = ST_IDLE;
               abort_go  = 1'b1;
            end else if (ph_cnt == CNT_W'(WIN_CYC - 1)) begin
               state_nxt = ST_EVAL;
            end
         end
         ST_EVAL: begin
            state_nxt = ST_IDLE;
            if (en_chg) begin
               abort_go = 1'b1;
            end else begin
               eval_ok = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // A set from EVAL overrides a simultaneous clear on the same bit.
   assign eval_set  = eval_ok ? (ge_thr & mask) : '0;
   assign fault_nxt = ((fault_clr ? '0 : chn_fault) | eval_set) & mask;

   always_ff @(posedge clk_12_5m) begin
      if (rst_12_5m) begin
         state      <= ST_IDLE;
         ph_cnt     <= '0;
         chn_en_q   <= chn_enable;
         chn_fault  <= '0;
         slink_err  <= 1'b0;
         diag_done  <= 1'b0;
         diag_abort <= 1'b0;
      end else begin
         state      <= state_nxt;
         ph_cnt     <= ((state_nxt != state) || (state == ST_IDLE)) ? '0 : ph_cnt + 1'b1;
         chn_en_q   <= chn_enable;
         chn_fault  <= fault_nxt;
         slink_err  <= |fault_nxt;
         diag_done  <= eval_ok;
         diag_abort <= abort_go;
      end
   end

   assign diag_busy = (state != ST_IDLE);

   for (genvar i = 0; i < CHN_NUM; i++) begin : g_cnt
      self_ex_slink_err_cnt #(
         .CNT_W   (CNT_W),
         .ERR_THR (ERR_THR)
      ) u_cnt (
         .clk_12_5m (clk_12_5m),
         .rst_12_5m (rst_12_5m),
         .clr       (run_go),
         .en        (smp_en),
         .inc       (chn_slink_err[i] & mask[i]),
         .ge_thr    (ge_thr[i])
      );
   end

endmodule
